// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the set-associative read cache.
//   state_t     - controller states
//   off_w/tag_w - derived address-field widths from the block parameters
//   addr_field  - extract an arbitrary bit field from a byte address
//   line_base   - clear the word/offset bits to get a line-aligned address
// Addresses are handled as 64-bit values inside the helpers so one set of
// functions serves every ADDR_W up to 64; callers size-cast the result.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESPOND,
        S_FLUSH
    } state_t;

    localparam int MAX_ADDR_W = 64;
    typedef logic [MAX_ADDR_W-1:0] addr_t;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int tag_w(input int addr_w, input int data_w,
                                 input int words, input int sets);
        return addr_w - $clog2(sets) - $clog2(words) - off_w(data_w);
    endfunction

    function automatic addr_t addr_field(input addr_t addr, input int lsb,
                                         input int width);
        addr_t mask;
        mask = (addr_t'(1) << width) - addr_t'(1);
        return (addr >> lsb) & mask;
    endfunction

    function automatic addr_t line_base(input addr_t addr, input int low_w);
        return (addr >> low_w) << low_w;
    endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if: core load port, memory refill port and flush handshake.
//   req_valid/req_addr/req_ready         - lookup request from the core
//   resp_valid/resp_hit/resp_data        - one-cycle response pulse
//   mem_req_valid/mem_req_addr/ready     - line refill request to memory
//   mem_rvalid/mem_rdata                 - refill beats, word 0 first
//   flush/flush_done                     - invalidate-all pulse and completion
// modport slave is the cache side; modport master is the core/memory side.
interface set_assoc_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              flush;
    logic              flush_done;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_rvalid, mem_rdata, flush,
        output req_ready, resp_valid, resp_hit, resp_data,
               mem_req_valid, mem_req_addr, flush_done
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_rvalid, mem_rdata, flush,
        input  req_ready, resp_valid, resp_hit, resp_data,
               mem_req_valid, mem_req_addr, flush_done
    );
endinterface

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the way to refill within one set.
//   valid   in  per-way valid bits of the set
//   rr      in  set's round-robin pointer
//   victim  out chosen way
//   advance out 1 when the round-robin pointer was used and must step
// The lowest-index invalid way wins; only a full set falls back to rr.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] rr,
    output logic [WAY_W-1:0] victim,
    output logic             advance
);

    always_comb begin
        victim  = rr;
        advance = 1'b1;
        // Descending scan so the lowest invalid index is the last assignment.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim  = WAY_W'(w);
                advance = 1'b0;
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative read cache with line refill.
//   clk, rst_n  - clock and asynchronous active-low reset
//   bus         - set_assoc_cache_if.slave (request, response, refill, flush)
//   hit_count   - saturating count of lookups served from the cache
//   miss_count  - saturating count of lookups that needed a refill
// Tag, valid and data storage are flop arrays. A lookup takes one cycle after
// acceptance; misses fetch a whole line, install it, then answer from the
// line buffer. Flush walks one set per cycle and is deferred to IDLE.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int WORDS  = 4,
    parameter int WAYS   = 8,
    parameter int SETS   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    set_assoc_cache_if.slave    bus,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int WRD_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_w(ADDR_W, DATA_W, WORDS, SETS);
    localparam int WAY_W = $clog2(WAYS);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]             tag_q;
    logic [SETS-1:0][WAYS-1:0][WORDS-1:0][DATA_W-1:0] data_q;
    logic [SETS-1:0][WAYS-1:0]                        vld_q;
    logic [SETS-1:0][WAY_W-1:0]                       rr_q;

    logic [WORDS-1:0][DATA_W-1:0] lbuf_q;
    logic [WORDS-1:0][DATA_W-1:0] line_w;
    logic [WORDS-1:0][DATA_W-1:0] hit_line;
    logic [WRD_W-1:0]             beat_q;
    logic [IDX_W-1:0]             fcnt_q;
    logic                         flush_pend_q;
    logic [WAY_W-1:0]             victim_q;
    logic [WAY_W-1:0]             victim;
    logic                         rr_adv;

    logic              resp_valid_q;
    logic              resp_hit_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              mreq_valid_q;
    logic [ADDR_W-1:0] mreq_addr_q;

    logic [IDX_W-1:0] set_idx;
    logic [TAG_W-1:0] tag;
    logic [WRD_W-1:0] word;
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic             req_ready;
    logic             last_beat;
    logic             flush_last;

    // Address fields of the registered request.
    assign word    = WRD_W'(addr_field(addr_t'(addr_q), OFF_W, WRD_W));
    assign set_idx = IDX_W'(addr_field(addr_t'(addr_q), OFF_W + WRD_W, IDX_W));
    assign tag     = TAG_W'(addr_field(addr_t'(addr_q), OFF_W + WRD_W + IDX_W, TAG_W));

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign hit_vec[w] = vld_q[set_idx][w] && (tag_q[set_idx][w] == tag);
    end
    assign hit = |hit_vec;

    // A tag is only installed after missing, so at most one way matches and an
    // OR-reduction is a valid mux.
    always_comb begin
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_line = hit_line | data_q[set_idx][w];
        end
    end

    cache_victim_sel #(.WAYS(WAYS)) u_vsel (
        .valid   (vld_q[set_idx]),
        .rr      (rr_q[set_idx]),
        .victim  (victim),
        .advance (rr_adv)
    );

    // Beats arrive in order, so the final beat is always the top word.
    always_comb begin
        line_w            = lbuf_q;
        line_w[WORDS-1]   = bus.mem_rdata;
    end

    assign last_beat  = (state_q == S_REFILL) && bus.mem_rvalid &&
                        (beat_q == WRD_W'(WORDS - 1));
    assign flush_last = (state_q == S_FLUSH) && (fcnt_q == IDX_W'(SETS - 1));

    // Ready is withheld during the response pulse so a core never sees ready
    // before it has seen the answer to its previous request.
    assign req_ready = (state_q == S_IDLE) && !flush_pend_q && !bus.flush &&
                       !resp_valid_q;

    assign bus.req_ready     = req_ready;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.mem_req_valid = mreq_valid_q;
    assign bus.mem_req_addr  = mreq_addr_q;
    assign bus.flush_done    = flush_last;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_pend_q || bus.flush)           state_d = S_FLUSH;
                else if (bus.req_valid && req_ready)     state_d = S_LOOKUP;
            end
            S_LOOKUP:   state_d = hit ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ: if (bus.mem_req_ready) state_d = S_REFILL;
            S_REFILL:   if (last_beat) state_d = S_RESPOND;
            S_RESPOND:  state_d = S_IDLE;
            S_FLUSH:    if (flush_last) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            vld_q        <= '0;
            rr_q         <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            fcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            mreq_valid_q <= 1'b0;
            mreq_addr_q  <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            // IDLE either starts the pending flush or has none; elsewhere
            // pulses accumulate into one pending flush.
            if (state_q == S_IDLE) flush_pend_q <= 1'b0;
            else                   flush_pend_q <= flush_pend_q | bus.flush;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready) addr_q <= bus.req_addr;
                end
                S_LOOKUP: begin
                    if (hit) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_data_q  <= hit_line[word];
                        if (hit_count != '1) hit_count <= hit_count + 32'd1;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        victim_q     <= victim;
                        if (rr_adv) rr_q[set_idx] <= rr_q[set_idx] + WAY_W'(1);
                        mreq_valid_q <= 1'b1;
                        mreq_addr_q  <= ADDR_W'(line_base(addr_t'(addr_q), WRD_W + OFF_W));
                    end
                end
                S_MISS_REQ: begin
                    if (bus.mem_req_ready) begin
                        mreq_valid_q <= 1'b0;
                        beat_q       <= '0;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_rvalid) begin
                        beat_q <= beat_q + WRD_W'(1);
                        if (last_beat) vld_q[set_idx][victim_q] <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= 1'b0;
                    resp_data_q  <= lbuf_q[word];
                end
                S_FLUSH: begin
                    vld_q[fcnt_q] <= '0;
                    rr_q[fcnt_q]  <= '0;
                    fcnt_q        <= fcnt_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage without reset: contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && bus.mem_rvalid) lbuf_q[beat_q] <= bus.mem_rdata;
        if (last_beat) begin
            tag_q[set_idx][victim_q]  <= tag;
            data_q[set_idx][victim_q] <= line_w;
        end
    end

endmodule
